// File: rtl/m68k_bus_master.sv
// FPGA-side 68000 bus initiator: arbitrates for the bus via BRn/BGn/BGACKn and runs one
// asynchronous read or write word cycle per fabric request.

module m68k_bus_master_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   // Bus control pins idle high, so the synchroniser resets to the negated level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

module m68k_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned HOLD_CYCLES    = 1
) (
   input  logic        clk12,
   input  logic        rst,
   input  logic        req,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic [1:0]  req_be,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        ack,
   output logic        err,
   output logic [15:0] rdata,
   input  logic        BGn,
   input  logic        ASn_in,
   input  logic        DTACKn_in,
   input  logic        BERRn_in,
   input  logic [15:0] data_in,
   output logic        BRn,
   output logic        BGACKn,
   output logic [22:0] addr_out,
   output logic        addr_oe,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        ASn_out,
   output logic        UDSn_out,
   output logic        LDSn_out,
   output logic        R_Wn_out,
   output logic        ctl_oe
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_OWN, S_ASSERT, S_DSTRB, S_WAIT, S_NEG, S_REL
   } state_t;

   state_t state_q, state_d;

   logic          bgn_s, asn_s, dtackn_s, berrn_s;
   logic          we_q, we_d;
   logic [22:0]   addr_q, addr_d;
   logic [1:0]    be_q, be_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          busy_q, busy_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          brn_q, brn_d;
   logic          bgackn_q, bgackn_d;
   logic          addr_oe_q, addr_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          ctl_oe_q, ctl_oe_d;
   logic          asn_q, asn_d;
   logic          udsn_q, udsn_d;
   logic          ldsn_q, ldsn_d;
   logic          rwn_q, rwn_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          wait_exit;

   m68k_bus_master_sync u_sync_bg    (.clk_i(clk12), .rst_i(rst), .d_i(BGn),       .q_o(bgn_s));
   m68k_bus_master_sync u_sync_as    (.clk_i(clk12), .rst_i(rst), .d_i(ASn_in),    .q_o(asn_s));
   m68k_bus_master_sync u_sync_dtack (.clk_i(clk12), .rst_i(rst), .d_i(DTACKn_in), .q_o(dtackn_s));
   m68k_bus_master_sync u_sync_berr  (.clk_i(clk12), .rst_i(rst), .d_i(BERRn_in),  .q_o(berrn_s));

   always_ff @(posedge clk12) begin
      if (rst) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         brn_q     <= 1'b1;
         bgackn_q  <= 1'b1;
         addr_oe_q <= 1'b0;
         data_oe_q <= 1'b0;
         ctl_oe_q  <= 1'b0;
         asn_q     <= 1'b1;
         udsn_q    <= 1'b1;
         ldsn_q    <= 1'b1;
         rwn_q     <= 1'b1;
         tcnt_q    <= '0;
         hcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         brn_q     <= brn_d;
         bgackn_q  <= bgackn_d;
         addr_oe_q <= addr_oe_d;
         data_oe_q <= data_oe_d;
         ctl_oe_q  <= ctl_oe_d;
         asn_q     <= asn_d;
         udsn_q    <= udsn_d;
         ldsn_q    <= ldsn_d;
         rwn_q     <= rwn_d;
         tcnt_q    <= tcnt_d;
         hcnt_q    <= hcnt_d;
      end
   end

   // Every output register is updated on the transition out of a state, so its new value
   // is visible for the whole of the following state.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      ack_d     = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      brn_d     = brn_q;
      bgackn_d  = bgackn_q;
      addr_oe_d = addr_oe_q;
      data_oe_d = data_oe_q;
      ctl_oe_d  = ctl_oe_q;
      asn_d     = asn_q;
      udsn_d    = udsn_q;
      ldsn_d    = ldsn_q;
      rwn_d     = rwn_q;
      tcnt_d    = tcnt_q;
      hcnt_d    = hcnt_q;
      wait_exit = 1'b0;

      case (state_q)
         S_IDLE: begin
            // ack_q high means this is the completion cycle; a request here must wait.
            if (req && !ack_q) begin
               we_d    = req_we;
               addr_d  = req_addr;
               be_d    = (req_be == 2'b00) ? 2'b11 : req_be;
               wdata_d = req_wdata;
               busy_d  = 1'b1;
               brn_d   = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (!bgn_s && asn_s && dtackn_s) begin
               bgackn_d = 1'b0;
               state_d  = S_OWN;
            end
         end
         S_OWN: begin
            brn_d     = 1'b1;
            addr_oe_d = 1'b1;
            ctl_oe_d  = 1'b1;
            rwn_d     = ~we_q;
            data_oe_d = we_q;
            state_d   = S_ASSERT;
         end
         S_ASSERT: begin
            asn_d  = 1'b0;
            tcnt_d = '0;
            if (we_q) begin
               state_d = S_DSTRB;
            end else begin
               udsn_d  = ~be_q[1];
               ldsn_d  = ~be_q[0];
               state_d = S_WAIT;
            end
         end
         S_DSTRB: begin
            udsn_d  = ~be_q[1];
            ldsn_d  = ~be_q[0];
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tcnt_d = tcnt_q + 1'b1;
            if (!berrn_s) begin
               err_d     = 1'b1;
               wait_exit = 1'b1;
            end else if (!dtackn_s) begin
               err_d     = 1'b0;
               if (!we_q) rdata_d = data_in;
               wait_exit = 1'b1;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d     = 1'b1;
               wait_exit = 1'b1;
            end
            if (wait_exit) begin
               asn_d   = 1'b1;
               udsn_d  = 1'b1;
               ldsn_d  = 1'b1;
               hcnt_d  = '0;
               state_d = S_NEG;
            end
         end
         S_NEG: begin
            if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = S_REL;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         S_REL: begin
            if (dtackn_s && berrn_s) begin
               addr_oe_d = 1'b0;
               data_oe_d = 1'b0;
               ctl_oe_d  = 1'b0;
               rwn_d     = 1'b1;
               bgackn_d  = 1'b1;
               ack_d     = 1'b1;
               busy_d    = 1'b0;
               tcnt_d    = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign BRn      = brn_q;
   assign BGACKn   = bgackn_q;
   assign addr_out = addr_q;
   assign addr_oe  = addr_oe_q;
   assign data_out = wdata_q;
   assign data_oe  = data_oe_q;
   assign ASn_out  = asn_q;
   assign UDSn_out = udsn_q;
   assign LDSn_out = ldsn_q;
   assign R_Wn_out = rwn_q;
   assign ctl_oe   = ctl_oe_q;
endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: a 68000-side arbiter and DTACK responder with word memory,
// checked against a transfer-level model of results and memory contents.

module tb_m68k_bus_master;
   localparam int TIMEOUT = 256;
   localparam int HOLD    = 1;

   logic        clk12 = 1'b0;
   logic        rst;
   logic        req, req_we;
   logic [22:0] req_addr;
   logic [1:0]  req_be;
   logic [15:0] req_wdata;
   logic        busy, ack, err;
   logic [15:0] rdata;
   logic        BGn, DTACKn_in, BERRn_in;
   logic        BRn, BGACKn;
   logic [22:0] addr_out;
   logic        addr_oe, data_oe, ctl_oe;
   logic [15:0] data_out;
   logic        ASn_out, UDSn_out, LDSn_out, R_Wn_out;

   logic        ext_as_n;
   logic [15:0] resp_data;
   logic        as_pin;
   logic [15:0] data_pin;

   int          resp_mode;   // 0 DTACK, 1 silent, 2 BERR together with DTACK
   int          resp_delay;
   int          grant_delay;

   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   logic [22:0] last_addr;
   logic [15:0] exp_rdata;
   int          n_chk, n_err;

   typedef struct {
      bit          got;
      bit          err_v;
      logic [15:0] rdata_v;
      int          c_ack, c_ds, c_uds, c_doe;
      bit          lds_low, brn_low, bgack_at_ds;
   } obs_t;

   assign as_pin   = ctl_oe  ? ASn_out  : ext_as_n;
   assign data_pin = data_oe ? data_out : resp_data;

   always #5 clk12 = ~clk12;

   m68k_bus_master #(.TIMEOUT_CYCLES(TIMEOUT), .HOLD_CYCLES(HOLD)) dut (
      .clk12(clk12), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_be(req_be), .req_wdata(req_wdata), .busy(busy), .ack(ack), .err(err),
      .rdata(rdata), .BGn(BGn), .ASn_in(as_pin), .DTACKn_in(DTACKn_in),
      .BERRn_in(BERRn_in), .data_in(data_pin), .BRn(BRn), .BGACKn(BGACKn),
      .addr_out(addr_out), .addr_oe(addr_oe), .data_out(data_out), .data_oe(data_oe),
      .ASn_out(ASn_out), .UDSn_out(UDSn_out), .LDSn_out(LDSn_out), .R_Wn_out(R_Wn_out),
      .ctl_oe(ctl_oe)
   );

   function automatic logic [15:0] init_word(input int i);
      if (i == 12'h400) return 16'hBEEF;
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   // 68000 arbiter: grants grant_delay cycles after BRn falls, withdraws once BRn rises.
   initial begin
      int gcnt;
      gcnt = 0;
      BGn  = 1'b1;
      forever begin
         @(negedge clk12);
         if (rst || BRn) begin
            BGn  = 1'b1;
            gcnt = 0;
         end else if (gcnt >= grant_delay) begin
            BGn = 1'b0;
         end else begin
            gcnt++;
         end
      end
   end

   // Slave responder with memory, answering once a data strobe is seen on the bus.
   initial begin
      int phase, dly;
      logic [11:0] idx;
      phase = 0; dly = 0;
      DTACKn_in = 1'b1; BERRn_in = 1'b1; resp_data = '0; last_addr = '0;
      for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
      forever begin
         @(negedge clk12);
         if (rst) begin
            DTACKn_in = 1'b1; BERRn_in = 1'b1; phase = 0;
         end else begin
            case (phase)
               0: if (ctl_oe && !as_pin && (!UDSn_out || !LDSn_out)) begin dly = 0; phase = 1; end
               1: begin
                  if (as_pin) phase = 0;
                  else if (dly >= resp_delay) begin
                     last_addr = addr_out;
                     idx = addr_out[11:0];
                     if (resp_mode == 0) begin
                        if (R_Wn_out) resp_data = mem[idx];
                        else begin
                           if (!UDSn_out) mem[idx][15:8] = data_pin[15:8];
                           if (!LDSn_out) mem[idx][7:0]  = data_pin[7:0];
                        end
                        DTACKn_in = 1'b0;
                     end else if (resp_mode == 2) begin
                        resp_data = 16'hDEAD;
                        DTACKn_in = 1'b0;
                        BERRn_in  = 1'b0;
                     end
                     phase = 2;
                  end else dly++;
               end
               default: if (as_pin) begin DTACKn_in = 1'b1; BERRn_in = 1'b1; phase = 0; end
            endcase
         end
      end
   end

   // Transfer-level model: outcome and memory effect of one request.
   task automatic model_xfer(input logic we, input logic [22:0] a, input logic [1:0] be,
                             input logic [15:0] wd, input int mode,
                             output logic e_err, output logic [15:0] e_rd);
      logic [1:0]  b;
      logic [11:0] idx;
      b   = (be == 2'b00) ? 2'b11 : be;
      idx = a[11:0];
      if (mode == 0) begin
         e_err = 1'b0;
         if (we) begin
            if (b[1]) ref_mem[idx][15:8] = wd[15:8];
            if (b[0]) ref_mem[idx][7:0]  = wd[7:0];
         end else begin
            exp_rdata = ref_mem[idx];
         end
      end else begin
         e_err = 1'b1;
      end
      e_rd = exp_rdata;
   endtask

   task automatic issue(input logic we, input logic [22:0] a, input logic [1:0] be,
                        input logic [15:0] wd);
      @(negedge clk12);
      req = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
      @(negedge clk12);
      req = 1'b0;
   endtask

   task automatic wait_ack(input int budget, output obs_t o);
      o.got = 0; o.err_v = 0; o.rdata_v = '0; o.c_ack = -1; o.c_ds = -1; o.c_uds = -1;
      o.c_doe = -1; o.lds_low = 0; o.brn_low = 0; o.bgack_at_ds = 0;
      for (int c = 0; c < budget; c++) begin
         if (!BRn) o.brn_low = 1;
         if (data_oe && o.c_doe < 0) o.c_doe = c;
         if (!UDSn_out && o.c_uds < 0) o.c_uds = c;
         if (!LDSn_out) o.lds_low = 1;
         if ((!UDSn_out || !LDSn_out) && o.c_ds < 0) begin
            o.c_ds = c;
            o.bgack_at_ds = !BGACKn;
         end
         if (ack) begin
            o.got = 1; o.c_ack = c; o.err_v = err; o.rdata_v = rdata;
            return;
         end
         @(negedge clk12);
      end
   endtask

   task automatic test_reset();
      logic [11:0] got;
      @(negedge clk12);
      got = {BRn, BGACKn, ASn_out, UDSn_out, LDSn_out, R_Wn_out,
             addr_oe, data_oe, ctl_oe, busy, ack, err};
      n_chk++;
      if (got !== 12'b111111_000000) begin
         n_err++; $display("FAIL reset_ctl: got %b expected %b", got, 12'b111111_000000);
      end
      n_chk++;
      if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
      rst = 1'b0;
      repeat (2) @(negedge clk12);
   endtask

   task automatic test_read();
      obs_t o; logic e_err; logic [15:0] e_rd;
      grant_delay = 3; resp_mode = 0; resp_delay = 1;
      issue(1'b0, 23'h000400, 2'b11, '0);
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000400, 2'b11, '0, 0, e_err, e_rd);
      n_chk++;
      if (!(o.got && o.brn_low && o.bgack_at_ds)) begin
         n_err++; $display("FAIL read_handshake: got ack=%0d brn_low=%0d bgack=%0d expected 1 1 1",
                           o.got, o.brn_low, o.bgack_at_ds);
      end
      n_chk++;
      if (o.err_v !== e_err || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL read_data: got err=%0d rdata=%h expected err=%0d rdata=%h",
                           o.err_v, o.rdata_v, e_err, e_rd);
      end
      n_chk++;
      if (last_addr !== 23'h000400) begin n_err++; $display("FAIL read_addr: got %h expected 000400", last_addr); end
      @(negedge clk12);
      n_chk++;
      if ({ack, BRn, BGACKn} !== 3'b011) begin
         n_err++; $display("FAIL read_release: got ack/BRn/BGACKn=%b expected 011", {ack, BRn, BGACKn});
      end
   endtask

   task automatic test_write();
      obs_t o; logic e_err; logic [15:0] e_rd;
      resp_mode = 0; resp_delay = 0; grant_delay = 1;
      issue(1'b1, 23'h001000, 2'b10, 16'h1234);
      wait_ack(1000, o);
      model_xfer(1'b1, 23'h001000, 2'b10, 16'h1234, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.err_v !== e_err) begin
         n_err++; $display("FAIL write_ack: got ack=%0d err=%0d expected 1 %0d", o.got, o.err_v, e_err);
      end
      n_chk++;
      if (o.c_doe < 0 || o.c_uds < 0 || o.c_doe >= o.c_uds) begin
         n_err++; $display("FAIL write_setup: got data_oe at %0d UDSn low at %0d expected data_oe first",
                           o.c_doe, o.c_uds);
      end
      n_chk++;
      if (o.lds_low) begin n_err++; $display("FAIL write_lds: got LDSn low expected LDSn held 1"); end
      n_chk++;
      if (mem[0][15:8] !== 8'h12 || mem[0] !== ref_mem[0]) begin
         n_err++; $display("FAIL write_mem: got %h expected %h", mem[0], ref_mem[0]);
      end
   endtask

   task automatic test_bus_busy();
      obs_t o; logic e_err; logic [15:0] e_rd; bit granted, early; int lat;
      grant_delay = 0; resp_delay = 0; resp_mode = 0; ext_as_n = 1'b0;
      issue(1'b0, 23'h000ABC, 2'b11, '0);
      granted = 0;
      for (int i = 0; i < 20 && !granted; i++) begin
         if (!BGn) granted = 1;
         else @(negedge clk12);
      end
      early = 0;
      repeat (5) begin
         @(negedge clk12);
         if (!BGACKn) early = 1;
      end
      n_chk++;
      if (!granted || early) begin
         n_err++; $display("FAIL busy_hold: got granted=%0d bgack_early=%0d expected 1 0", granted, early);
      end
      ext_as_n = 1'b1;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         @(negedge clk12);
         if (!BGACKn) lat = i;
      end
      // two synchroniser flops plus the registered BGACKn
      n_chk++;
      if (lat !== 3) begin n_err++; $display("FAIL busy_bgack_latency: got %0d expected 3", lat); end
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000ABC, 2'b11, '0, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.err_v !== e_err || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL busy_xfer: got ack=%0d err=%0d rdata=%h expected 1 %0d %h",
                           o.got, o.err_v, o.rdata_v, e_err, e_rd);
      end
   endtask

   task automatic test_timeout();
      obs_t o; logic e_err; logic [15:0] e_rd; int lat;
      resp_mode = 1; grant_delay = 2;
      issue(1'b0, 23'h000123, 2'b11, '0);
      wait_ack(2000, o);
      model_xfer(1'b0, 23'h000123, 2'b11, '0, 1, e_err, e_rd);
      lat = o.c_ack - o.c_ds;
      // TIMEOUT cycles waiting, HOLD cycles negated, one release cycle
      n_chk++;
      if (!o.got || o.c_ds < 0 || lat !== TIMEOUT + HOLD + 1) begin
         n_err++; $display("FAIL timeout_latency: got ack=%0d cycles=%0d expected 1 %0d",
                           o.got, lat, TIMEOUT + HOLD + 1);
      end
      n_chk++;
      if (o.err_v !== e_err || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL timeout_result: got err=%0d rdata=%h expected %0d %h",
                           o.err_v, o.rdata_v, e_err, e_rd);
      end
      @(negedge clk12);
      n_chk++;
      if ({addr_oe, data_oe, ctl_oe, BGACKn, ack} !== 5'b00010) begin
         n_err++; $display("FAIL timeout_release: got oe/BGACKn/ack=%b expected 00010",
                           {addr_oe, data_oe, ctl_oe, BGACKn, ack});
      end
   endtask

   task automatic test_berr();
      obs_t o; logic e_err; logic [15:0] e_rd;
      resp_mode = 0; resp_delay = 0; grant_delay = 0;
      issue(1'b0, 23'h000222, 2'b11, '0);
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000222, 2'b11, '0, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL berr_prior_read: got ack=%0d rdata=%h expected 1 %h", o.got, o.rdata_v, e_rd);
      end
      resp_mode = 2;
      issue(1'b0, 23'h000333, 2'b11, '0);
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000333, 2'b11, '0, 2, e_err, e_rd);
      n_chk++;
      if (!o.got || o.err_v !== e_err || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL berr_result: got ack=%0d err=%0d rdata=%h expected 1 %0d %h",
                           o.got, o.err_v, o.rdata_v, e_err, e_rd);
      end
      resp_mode = 0;
   endtask

   task automatic test_reset_midcycle();
      obs_t o; logic e_err; logic [15:0] e_rd; bit found, saw_ack; logic [7:0] got;
      resp_mode = 1; grant_delay = 1;
      issue(1'b0, 23'h000044, 2'b11, '0);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk12);
         if (!UDSn_out) found = 1;
      end
      n_chk++;
      if (!found) begin n_err++; $display("FAIL rstmid_strobe: got no DS expected DS asserted"); end
      repeat (10) @(negedge clk12);
      rst = 1'b1;
      @(negedge clk12);
      rst = 1'b0;
      exp_rdata = '0;
      got = {BRn, BGACKn, addr_oe, data_oe, ctl_oe, busy, ack, err};
      n_chk++;
      if (got !== 8'b11000000 || rdata !== exp_rdata) begin
         n_err++; $display("FAIL rstmid_state: got %b rdata=%h expected 11000000 rdata=%h", got, rdata, exp_rdata);
      end
      saw_ack = 0;
      repeat (20) begin
         @(negedge clk12);
         if (ack) saw_ack = 1;
      end
      n_chk++;
      if (saw_ack) begin n_err++; $display("FAIL rstmid_noack: got ack expected none"); end
      resp_mode = 0;
      issue(1'b0, 23'h000055, 2'b11, '0);
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000055, 2'b11, '0, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.err_v !== e_err || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL rstmid_after: got ack=%0d err=%0d rdata=%h expected 1 %0d %h",
                           o.got, o.err_v, o.rdata_v, e_err, e_rd);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o; logic e_err; logic [15:0] e_rd; logic [15:0] wd;
      resp_mode = 0; resp_delay = 0; grant_delay = 0;
      wd = 16'($urandom);
      issue(1'b0, 23'h000066, 2'b11, '0);
      wait_ack(1000, o);
      model_xfer(1'b0, 23'h000066, 2'b11, '0, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.rdata_v !== e_rd) begin
         n_err++; $display("FAIL b2b_first: got ack=%0d rdata=%h expected 1 %h", o.got, o.rdata_v, e_rd);
      end
      req = 1'b1; req_we = 1'b1; req_addr = 23'h000077; req_be = 2'b11; req_wdata = wd;
      @(negedge clk12);
      n_chk++;
      if ({ack, busy} !== 2'b00) begin
         n_err++; $display("FAIL b2b_ack_cycle: got ack/busy=%b expected 00", {ack, busy});
      end
      @(negedge clk12);
      req = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
      wait_ack(1000, o);
      model_xfer(1'b1, 23'h000077, 2'b11, wd, 0, e_err, e_rd);
      n_chk++;
      if (!o.got || o.err_v !== e_err || mem[12'h077] !== ref_mem[12'h077]) begin
         n_err++; $display("FAIL b2b_second: got ack=%0d err=%0d mem=%h expected 1 %0d %h",
                           o.got, o.err_v, mem[12'h077], e_err, ref_mem[12'h077]);
      end
   endtask

   task automatic test_random();
      obs_t o; logic e_err; logic [15:0] e_rd;
      logic we; logic [22:0] a; logic [1:0] be; logic [15:0] wd; int mode;
      for (int n = 0; n < 25; n++) begin
         we = 1'($urandom); a = 23'($urandom); be = 2'($urandom); wd = 16'($urandom);
         mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
         resp_mode = mode; grant_delay = $urandom_range(0, 4); resp_delay = $urandom_range(0, 3);
         issue(we, a, be, wd);
         wait_ack(1000, o);
         model_xfer(we, a, be, wd, mode, e_err, e_rd);
         n_chk++;
         if (!o.got || o.err_v !== e_err || o.rdata_v !== e_rd || last_addr !== a) begin
            n_err++; $display("FAIL rand_%0d: got ack=%0d err=%0d rdata=%h addr=%h expected 1 %0d %h %h",
                              n, o.got, o.err_v, o.rdata_v, last_addr, e_err, e_rd, a);
         end
         n_chk++;
         if (mem[a[11:0]] !== ref_mem[a[11:0]]) begin
            n_err++; $display("FAIL rand_mem_%0d: got %h expected %h", n, mem[a[11:0]], ref_mem[a[11:0]]);
         end
      end
      resp_mode = 0;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
      ext_as_n = 1'b1; resp_mode = 0; resp_delay = 0; grant_delay = 0; exp_rdata = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clk12);
      test_reset();
      test_read();
      test_write();
      test_bus_busy();
      test_timeout();
      test_berr();
      test_reset_midcycle();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
